// File: rtl/intr_stat_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// Intr package
// Shared types and register map for the interrupt status controller.
//   intr_trig_type : trigger style of the downstream interrupt signal generator
//   intr_src_type  : how a source is captured into its sticky status bit
//   INTR_REG_*     : register port addresses (i_reg_addr encoding)
// -----------------------------------------------------------------------------
package Intr;

    // Trigger style used by the downstream interrupt signal generator.
    typedef enum logic [1:0] {
        TRIG_LEVEL  = 2'd0,
        TRIG_PULSE  = 2'd1,
        TRIG_TOGGLE = 2'd2
    } intr_trig_type;

    // Capture style of a single interrupt source.
    typedef enum logic {
        SRC_LEVEL = 1'b0,
        SRC_RISE  = 1'b1
    } intr_src_type;

    // Register map
    localparam logic [1:0] INTR_REG_STAT = 2'd0;  // sticky status, W1C
    localparam logic [1:0] INTR_REG_EN   = 2'd1;  // enable, R/W
    localparam logic [1:0] INTR_REG_PEND = 2'd2;  // stat & en, read-only
    localparam logic [1:0] INTR_REG_SET  = 2'd3;  // W1S test hook, reads 0

endpackage

// File: rtl/intr_stat_cell.sv
// -----------------------------------------------------------------------------
// intr_stat_cell
// One interrupt source: delayed source copy, set-condition logic and the
// sticky status flop.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   i_src  : raw source bit
//   i_w1c  : software clear request for this bit
//   i_w1s  : software set request for this bit
//   o_stat : sticky status bit
// -----------------------------------------------------------------------------
module intr_stat_cell
    import Intr::*;
#(
    parameter logic SRC_EDGE = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_src,
    input  logic i_w1c,
    input  logic i_w1s,
    output logic o_stat
);

    localparam intr_src_type SRC_TYPE = SRC_EDGE ? SRC_RISE : SRC_LEVEL;

    logic r_src_d;
    logic r_stat;
    logic w_set_cond;
    logic w_stat_nxt;

    // Set condition: rising edge or plain level depending on source type.
    always_comb begin
        w_set_cond = 1'b0;
        case (SRC_TYPE)
            SRC_RISE:  w_set_cond = i_src & ~r_src_d;
            SRC_LEVEL: w_set_cond = i_src;
            default:   w_set_cond = i_src;
        endcase
    end

    // Next status: a set in the same cycle as a clear wins, so no event is lost.
    always_comb begin
        w_stat_nxt = (r_stat & ~i_w1c) | w_set_cond | i_w1s;
    end

    // Source history and sticky status registers. src_d clears on reset so a
    // source already high at reset release is seen as a rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src_d <= 1'b0;
            r_stat  <= 1'b0;
        end else begin
            r_src_d <= i_src;
            r_stat  <= w_stat_nxt;
        end
    end

    assign o_stat = r_stat;

endmodule

// File: rtl/intr_stat_ctrl.sv
// -----------------------------------------------------------------------------
// intr_stat_ctrl
// Captures INTR_NUM interrupt sources into sticky status bits, gates them with
// a per-source enable and drives a registered aggregate status line plus the
// lowest pending source index to the downstream interrupt signal generator.
//   i_clk        : clock
//   i_rst        : synchronous active-high reset
//   i_src        : raw interrupt sources
//   i_reg_wen    : register write strobe
//   i_reg_ren    : register read strobe
//   i_reg_addr   : register select (STAT/EN/PEND/SET)
//   i_reg_wdata  : register write data
//   o_reg_rdata  : read data, held until the next read
//   o_reg_rvalid : read response, one cycle after i_reg_ren
//   o_intr_stat  : registered OR of (stat & en)
//   o_intr_id    : registered lowest index of (stat & en), 0 when none
// -----------------------------------------------------------------------------
module intr_stat_ctrl
    import Intr::*;
#(
    parameter int                  INTR_NUM = 8,
    parameter logic [INTR_NUM-1:0] SRC_EDGE = {INTR_NUM{1'b0}},
    parameter logic [INTR_NUM-1:0] EN_RST   = {INTR_NUM{1'b0}},
    localparam int                 IW       = (INTR_NUM > 1) ? $clog2(INTR_NUM) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [INTR_NUM-1:0] i_src,
    input  logic                i_reg_wen,
    input  logic                i_reg_ren,
    input  logic [1:0]          i_reg_addr,
    input  logic [INTR_NUM-1:0] i_reg_wdata,
    output logic [INTR_NUM-1:0] o_reg_rdata,
    output logic                o_reg_rvalid,
    output logic                o_intr_stat,
    output logic [IW-1:0]       o_intr_id
);

    logic [INTR_NUM-1:0] r_en;
    logic [INTR_NUM-1:0] r_rdata;
    logic                r_rvalid;
    logic                r_intr_stat;
    logic [IW-1:0]       r_intr_id;

    logic [INTR_NUM-1:0] w_stat;
    logic [INTR_NUM-1:0] w_pend;
    logic [INTR_NUM-1:0] w_w1c;
    logic [INTR_NUM-1:0] w_w1s;
    logic [INTR_NUM-1:0] w_rdata_nxt;
    logic [IW-1:0]       w_id;

    // Decode software clear/set requests into per-bit strobes.
    always_comb begin
        w_w1c = {INTR_NUM{1'b0}};
        w_w1s = {INTR_NUM{1'b0}};
        if (i_reg_wen && (i_reg_addr == INTR_REG_STAT)) begin
            w_w1c = i_reg_wdata;
        end else begin
            w_w1c = {INTR_NUM{1'b0}};
        end
        if (i_reg_wen && (i_reg_addr == INTR_REG_SET)) begin
            w_w1s = i_reg_wdata;
        end else begin
            w_w1s = {INTR_NUM{1'b0}};
        end
    end

    genvar g_k;
    generate
        for (g_k = 0; g_k < INTR_NUM; g_k++) begin : g_cell
            intr_stat_cell #(
                .SRC_EDGE (SRC_EDGE[g_k])
            ) u_cell (
                .i_clk  (i_clk),
                .i_rst  (i_rst),
                .i_src  (i_src[g_k]),
                .i_w1c  (w_w1c[g_k]),
                .i_w1s  (w_w1s[g_k]),
                .o_stat (w_stat[g_k])
            );
        end
    endgenerate

    assign w_pend = w_stat & r_en;

    // Lowest-index priority encoder: scanning downward lets the lowest set bit
    // be the last assignment.
    always_comb begin
        w_id = {IW{1'b0}};
        for (int k = INTR_NUM - 1; k >= 0; k--) begin
            if (w_pend[k]) begin
                w_id = k[IW-1:0];
            end else begin
                w_id = w_id;
            end
        end
    end

    // Read mux; uses current register values, so a same-cycle write is not seen.
    always_comb begin
        w_rdata_nxt = {INTR_NUM{1'b0}};
        case (i_reg_addr)
            INTR_REG_STAT: w_rdata_nxt = w_stat;
            INTR_REG_EN:   w_rdata_nxt = r_en;
            INTR_REG_PEND: w_rdata_nxt = w_pend;
            INTR_REG_SET:  w_rdata_nxt = {INTR_NUM{1'b0}};
            default:       w_rdata_nxt = {INTR_NUM{1'b0}};
        endcase
    end

    // Enable register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_en <= EN_RST;
        end else if (i_reg_wen && (i_reg_addr == INTR_REG_EN)) begin
            r_en <= i_reg_wdata;
        end
    end

    // Read response: rdata is only reloaded on a read and holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata  <= {INTR_NUM{1'b0}};
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= i_reg_ren;
            if (i_reg_ren) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    // Registered aggregate status and id toward the signal generator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_intr_stat <= 1'b0;
            r_intr_id   <= {IW{1'b0}};
        end else begin
            r_intr_stat <= |w_pend;
            r_intr_id   <= w_id;
        end
    end

    assign o_reg_rdata  = r_rdata;
    assign o_reg_rvalid = r_rvalid;
    assign o_intr_stat  = r_intr_stat;
    assign o_intr_id    = r_intr_id;

endmodule

// File: tb/tb_intr_stat_ctrl.sv
// -----------------------------------------------------------------------------
// tb_intr_stat_ctrl
// Directed scenarios followed by randomized traffic, all compared every cycle
// against a behavioural model of the status/enable/read behaviour.
// -----------------------------------------------------------------------------
module tb_intr_stat_ctrl;

    localparam int         N        = 8;
    localparam logic [7:0] SRC_EDGE = 8'hF7;  // source 3 level, others edge
    localparam logic [7:0] EN_RST   = 8'h00;

    logic       clk;
    logic       rst;
    logic [7:0] src;
    logic       wen;
    logic       ren;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] o_reg_rdata;
    logic       o_reg_rvalid;
    logic       o_intr_stat;
    logic [2:0] o_intr_id;

    int n_checks;
    int n_errors;

    // Model state
    logic [7:0] m_stat;
    logic [7:0] m_en;
    logic [7:0] m_prev_src;
    logic [7:0] m_rdata;
    logic       m_rvalid;
    logic       m_ostat;
    logic [2:0] m_id;

    intr_stat_ctrl #(
        .INTR_NUM (N),
        .SRC_EDGE (SRC_EDGE),
        .EN_RST   (EN_RST)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_src        (src),
        .i_reg_wen    (wen),
        .i_reg_ren    (ren),
        .i_reg_addr   (addr),
        .i_reg_wdata  (wdata),
        .o_reg_rdata  (o_reg_rdata),
        .o_reg_rvalid (o_reg_rvalid),
        .o_intr_stat  (o_intr_stat),
        .o_intr_id    (o_intr_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: predict from spec rules, clock, then compare all outputs.
    task automatic tick();
        logic [7:0] newly;
        logic [7:0] clr;
        logic [7:0] setw;
        logic [7:0] pending;
        logic [7:0] n_stat;
        logic [7:0] n_en;
        logic [7:0] n_rdata;
        logic       n_ostat;
        logic [2:0] n_id;
        logic       found;

        newly = 8'h00;
        for (int k = 0; k < N; k++) begin
            if (SRC_EDGE[k]) newly[k] = src[k] && !m_prev_src[k];
            else             newly[k] = src[k];
        end
        clr  = (wen && addr == 2'd0) ? wdata : 8'h00;
        setw = (wen && addr == 2'd3) ? wdata : 8'h00;
        n_stat = (m_stat & ~clr) | newly | setw;
        n_en   = (wen && addr == 2'd1) ? wdata : m_en;

        pending = m_stat & m_en;
        n_ostat = (pending != 8'h00);
        n_id    = 3'd0;
        found   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && pending[k]) begin
                n_id  = 3'(k);
                found = 1'b1;
            end
        end

        n_rdata = m_rdata;
        if (ren) begin
            if (addr == 2'd0)      n_rdata = m_stat;
            else if (addr == 2'd1) n_rdata = m_en;
            else if (addr == 2'd2) n_rdata = pending;
            else                   n_rdata = 8'h00;
        end

        @(posedge clk);
        if (rst) begin
            m_stat = 8'h00; m_en = EN_RST; m_prev_src = 8'h00;
            m_rdata = 8'h00; m_rvalid = 1'b0; m_ostat = 1'b0; m_id = 3'd0;
        end else begin
            m_stat = n_stat; m_en = n_en; m_prev_src = src;
            m_rdata = n_rdata; m_rvalid = ren; m_ostat = n_ostat; m_id = n_id;
        end
        #1;
        check_val("intr_stat", {31'd0, o_intr_stat}, {31'd0, m_ostat});
        check_val("intr_id", {29'd0, o_intr_id}, {29'd0, m_id});
        check_val("rvalid", {31'd0, o_reg_rvalid}, {31'd0, m_rvalid});
        check_val("rdata", {24'd0, o_reg_rdata}, {24'd0, m_rdata});
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
        wen = 1'b1; addr = a; wdata = d;
        tick();
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
        ren = 1'b1; addr = a;
        tick();
        check_val("rd_rvalid", {31'd0, o_reg_rvalid}, 32'd1);
        d = o_reg_rdata;
    endtask

    logic [7:0] rd;

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; src = 8'h00; wen = 1'b0; ren = 1'b0; addr = 2'd0; wdata = 8'h00;
        m_stat = 8'h00; m_en = EN_RST; m_prev_src = 8'h00;
        m_rdata = 8'h00; m_rvalid = 1'b0; m_ostat = 1'b0; m_id = 3'd0;

        // Reset release with idle sources
        tick(); tick();
        rst = 1'b0;
        tick();
        check_val("rst_ostat", {31'd0, o_intr_stat}, 32'd0);
        check_val("rst_rvalid_idle", {31'd0, o_reg_rvalid}, 32'd0);
        reg_rd(2'd0, rd); check_val("rst_stat", {24'd0, rd}, 32'h00);
        reg_rd(2'd1, rd); check_val("rst_en", {24'd0, rd}, 32'h00);
        reg_rd(2'd2, rd); check_val("rst_pend", {24'd0, rd}, 32'h00);
        tick();
        check_val("rvalid_one_cycle", {31'd0, o_reg_rvalid}, 32'd0);

        // Edge source 0 with enable, then W1C
        reg_wr(2'd1, 8'h01);
        src = 8'h01; tick();
        check_val("edge0_n1", {31'd0, o_intr_stat}, 32'd0);
        src = 8'h00; tick();
        check_val("edge0_n2", {31'd0, o_intr_stat}, 32'd1);
        check_val("edge0_id", {29'd0, o_intr_id}, 32'd0);
        reg_rd(2'd0, rd); check_val("edge0_stat", {24'd0, rd}, 32'h01);
        reg_wr(2'd0, 8'h01);
        check_val("w1c0_n1", {31'd0, o_intr_stat}, 32'd1);
        tick();
        check_val("w1c0_n2", {31'd0, o_intr_stat}, 32'd0);

        // Held level source 3 survives W1C until it drops
        src = 8'h08; tick(); tick();
        reg_wr(2'd0, 8'h08);
        reg_rd(2'd0, rd); check_val("level_held", {24'd0, rd}, 32'h08);
        src = 8'h00; tick();
        reg_wr(2'd0, 8'h08);
        reg_rd(2'd0, rd); check_val("level_clr", {24'd0, rd}, 32'h00);

        // Edge on source 2 coincident with its W1C
        src = 8'h04; wen = 1'b1; addr = 2'd0; wdata = 8'h04; tick();
        src = 8'h00;
        reg_rd(2'd0, rd); check_val("set_beats_clr", {24'd0, rd}, 32'h04);
        reg_wr(2'd0, 8'h04);

        // Disabled capture, then enable later
        reg_wr(2'd1, 8'h00);
        src = 8'h60; tick();
        src = 8'h00; tick();
        reg_rd(2'd0, rd); check_val("dis_stat", {24'd0, rd}, 32'h60);
        check_val("dis_ostat", {31'd0, o_intr_stat}, 32'd0);
        reg_wr(2'd1, 8'h60);
        tick();
        check_val("en_late_ostat", {31'd0, o_intr_stat}, 32'd1);
        check_val("en_late_id", {29'd0, o_intr_id}, 32'd5);
        reg_rd(2'd2, rd); check_val("en_late_pend", {24'd0, rd}, 32'h60);

        // SET then reset mid-operation
        reg_wr(2'd1, 8'hFF);
        reg_wr(2'd3, 8'h80);
        rst = 1'b1; tick();
        rst = 1'b0;
        check_val("midrst_ostat", {31'd0, o_intr_stat}, 32'd0);
        reg_rd(2'd0, rd); check_val("midrst_stat", {24'd0, rd}, 32'h00);
        reg_rd(2'd1, rd); check_val("midrst_en", {24'd0, rd}, {24'd0, EN_RST});

        // Source high across reset release counts as an edge
        src = 8'h01; rst = 1'b1; tick();
        rst = 1'b0; tick();
        src = 8'h00;
        reg_rd(2'd0, rd); check_val("rst_edge", {24'd0, rd}, 32'h01);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            src   = 8'($urandom);
            wen   = ($urandom_range(0, 3) == 0);
            ren   = ($urandom_range(0, 2) == 0);
            addr  = 2'($urandom_range(0, 3));
            wdata = 8'($urandom);
            rst   = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intr_stat_ctrl.md
# intr_stat_ctrl

- Collects up to `INTR_NUM` interrupt sources and captures each one into a sticky status bit.
- Applies a per-source enable and exposes status through a small register port.
- Drives one registered aggregate status line, `o_intr_stat`, into the interrupt signal generator directly downstream.
- `o_intr_stat` drops only after software clears every enabled pending bit. This lets the downstream generator leave its clear/wait state.

## Interface
Parameters:
- `INTR_NUM`, 8: number of sources, 1..32.
- `SRC_EDGE`, `'0`: `INTR_NUM`-bit vector; bit=1 means the source is rising-edge captured, bit=0 means level captured.
- `EN_RST`, `'0`: reset value of the enable register.

Ports:
- `i_clk`, input, 1: the block's only clock.
- `i_rst`, input, 1: synchronous, active-high reset.
- `i_src`, input, `INTR_NUM`: raw sources, synchronous to `i_clk`.
- `i_reg_wen`, input, 1: register write strobe, one cycle.
- `i_reg_ren`, input, 1: register read strobe, one cycle.
- `i_reg_addr`, input, 2: register select.
- `i_reg_wdata`, input, `INTR_NUM`: write data.
- `o_reg_rdata`, output, `INTR_NUM`: read data, valid with `o_reg_rvalid`.
- `o_reg_rvalid`, output, 1: read response, one cycle after `i_reg_ren`.
- `o_intr_stat`, output, 1: registered OR of (stat & en); goes to the downstream signal generator.
- `o_intr_id`, output, `$clog2(INTR_NUM)` (min 1): lowest index among enabled pending sources; 0 when none.

## Operation
Registers (selected by `i_reg_addr`):
- 0 STAT: sticky status; read returns stat; write is W1C.
- 1 EN: read/write enable.
- 2 PEND: read-only, stat & en; writes ignored.
- 3 SET: write-1-to-set stat (test hook); read returns 0.

Capture:
- `src_d` is a registered copy of `i_src`; it resets to 0.
- Edge source: set condition is `i_src[k] & ~src_d[k]`.
- Level source: set condition is `i_src[k]`, so the bit re-sets every cycle while the level is held.
- Next stat per bit: `(stat & ~w1c) | set_cond | w1s`.
  - Set beats clear on the same bit in the same cycle, so no event is lost.
- Capture is independent of EN. A disabled source still records status, and enabling it later raises `o_intr_stat` if its stat bit is set.

Outputs:
- `pend = stat & en`.
- `o_intr_stat` and `o_intr_id` are registered from `pend`, using a lowest-index priority encoder.
- Read and write in the same cycle: the read returns the pre-write value.
- `i_reg_wen` and `i_reg_ren` act independently; there is no backpressure.

## Timing
- Reset values:
  - `stat`, `src_d`, `o_intr_stat`, `o_intr_id`, `o_reg_rdata`, `o_reg_rvalid`: all 0.
  - `en`: `EN_RST`.
- A source already high when `i_rst` deasserts counts as a rising edge, because `src_d` is 0 out of reset.
- Source-to-output latency: set condition at edge n → `stat` at n+1 → `o_intr_stat`/`o_intr_id` at n+2.
- W1C at edge n → `stat` clear at n+1 → `o_intr_stat` low at n+2, provided no other enabled bit is pending.
- A held level source never clears. Software must quiesce the source first.
- Read latency: exactly 1 cycle. `o_reg_rdata` holds its value until the next read.
- `i_rst` asserted mid-operation: all state returns to reset values at the next edge. Pending events are discarded.

## Structure
- Package `Intr`:
  - add enum `intr_src_type {SRC_LEVEL, SRC_RISE}`;
  - add address constants `INTR_REG_STAT/EN/PEND/SET`;
  - the existing trigger-type enum stays unchanged.
- One sub-module, `intr_stat_cell`:
  - per-bit `src_d`, set-condition logic and sticky stat flop;
  - instantiated `INTR_NUM` times via generate, with `SRC_EDGE[k]` as its parameter.
- The top level holds the EN register, read mux, priority encoder and output registers.

## Test plan
- Reset release with `i_src`=0, EN_RST=0 → all outputs 0; read STAT/EN/PEND return 0x00 with rvalid one cycle after ren.
- EN=0x01, edge source 0 pulses one cycle at edge n → STAT=0x01, `o_intr_stat`=1 at n+2, `o_intr_id`=0. Then W1C 0x01 → `o_intr_stat`=0 two cycles later.
- Level source 3 held high, W1C 0x08 → STAT still 0x08. Drop the source, then W1C → cleared.
- Edge on source 2 in the same cycle as W1C 0x04 → STAT bit 2 stays 1.
- EN=0x00, pulse sources 5 and 6 → STAT=0x60, `o_intr_stat`=0. Write EN=0x60 → `o_intr_stat`=1, `o_intr_id`=5 two cycles later.
- SET write 0x80 with EN=0xFF, then assert `i_rst` one cycle later → STAT=0 and `o_intr_stat`=0 after the reset edge; EN returns to EN_RST.
